// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the FSM state encoding, the default drain depth and the register
// index width shared by the hazard logic.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int PIPE_DRAIN_DEF = 4;
  localparam int REG_W          = 5;

  // The drain counter must hold PIPE_DRAIN-1; keep at least one bit.
  function automatic int dcnt_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Control bus between the pipeline datapath and the sequencer.
//   master : datapath side, drives run/step/decode/hazard inputs, reads controls
//   slave  : sequencer side, reads inputs, drives enables/bubble/flush/stall/halt,
//            state and executed-cycle count
interface pipeline_sequencer_if #(
  parameter int NB_DATA = 32
);
  import pipeline_pkg::*;

  logic               i_run;
  logic               i_step;
  logic               i_halt_instr;
  logic               i_ex_memRead;
  logic [REG_W-1:0]   i_ex_rt;
  logic [REG_W-1:0]   i_id_rs;
  logic [REG_W-1:0]   i_id_rt;
  logic               i_branch_taken;

  logic               o_pc_en;
  logic               o_if_id_en;
  logic               o_bubble;
  logic               o_flush_if_id;
  logic               o_stall;
  logic               o_halt;
  logic [2:0]         o_state;
  logic [NB_DATA-1:0] o_cycles;

  modport master (
    output i_run, i_step, i_halt_instr, i_ex_memRead, i_ex_rt, i_id_rs, i_id_rt,
           i_branch_taken,
    input  o_pc_en, o_if_id_en, o_bubble, o_flush_if_id, o_stall, o_halt,
           o_state, o_cycles
  );

  modport slave (
    input  i_run, i_step, i_halt_instr, i_ex_memRead, i_ex_rt, i_id_rs, i_id_rt,
           i_branch_taken,
    output o_pc_en, o_if_id_en, o_bubble, o_flush_if_id, o_stall, o_halt,
           o_state, o_cycles
  );

endinterface

// File: rtl/pipeline_sequencer_hazard.sv
// Load-use hazard detector (purely combinational).
//   i_ex_memRead, i_ex_rt : load in EX and its destination
//   i_id_rs, i_id_rt      : sources of the instruction in ID
//   o_hazard              : ID must wait one cycle for the load result
module hazard_detector
  import pipeline_pkg::*;
(
  input  logic             i_ex_memRead,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  output logic             o_hazard
);

  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign o_hazard = i_ex_memRead && (i_ex_rt != '0) &&
                    ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: run/step/drain/halt control for a 5-stage pipeline.
//   clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)  : run/step requests, HALT decode, load-use operands and branch
//                  resolution in; PC/IFID enables, bubble, flush, stall, halt,
//                  state and saturating executed-cycle count out.
// Outputs are decoded combinationally from state and current inputs so hazard
// and branch responses take effect in the same cycle.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int PIPE_DRAIN = PIPE_DRAIN_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  pipeline_sequencer_if.slave bus
);

  localparam int DCNT_W = dcnt_width(PIPE_DRAIN);

  state_e              r_state, w_next;
  logic [DCNT_W-1:0]   r_dcnt, w_dcnt_nxt;
  logic [NB_DATA-1:0]  r_cycles;
  logic                w_hazard;
  logic                w_count;

  hazard_detector u_hazard (
    .i_ex_memRead (bus.i_ex_memRead),
    .i_ex_rt      (bus.i_ex_rt),
    .i_id_rs      (bus.i_id_rs),
    .i_id_rt      (bus.i_id_rt),
    .o_hazard     (w_hazard)
  );

  assign w_count = (r_state == ST_RUN) || (r_state == ST_STEP) ||
                   (r_state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_dcnt   <= '0;
      r_cycles <= '0;
    end else begin
      r_state <= w_next;
      r_dcnt  <= w_dcnt_nxt;
      if (w_count && (r_cycles != '1))
        r_cycles <= r_cycles + 1'b1;
    end
  end

  always_comb begin
    w_next             = r_state;
    w_dcnt_nxt         = r_dcnt;
    bus.o_pc_en        = 1'b0;
    bus.o_if_id_en     = 1'b0;
    bus.o_bubble       = 1'b0;
    bus.o_flush_if_id  = 1'b0;
    bus.o_stall        = 1'b1;
    bus.o_halt         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_run)       w_next = ST_RUN;
        else if (bus.i_step) w_next = ST_STEP;
      end

      ST_RUN, ST_STEP: begin
        bus.o_stall = 1'b0;
        // A single step always returns to IDLE unless a halt is taken below.
        if (r_state == ST_STEP) w_next = ST_IDLE;

        if (bus.i_branch_taken) begin
          // Redirect wins: anything in IF/ID (including a HALT) is wrong-path.
          bus.o_pc_en       = 1'b1;
          bus.o_if_id_en    = 1'b1;
          bus.o_flush_if_id = 1'b1;
          bus.o_bubble      = 1'b1;
        end else if (w_hazard) begin
          // Hold fetch and ID; HALT in ID is retried once the load clears.
          bus.o_bubble = 1'b1;
        end else if (bus.i_halt_instr) begin
          bus.o_bubble = 1'b1;
          w_next       = ST_DRAIN;
          w_dcnt_nxt   = DCNT_W'(PIPE_DRAIN - 1);
        end else begin
          bus.o_pc_en    = 1'b1;
          bus.o_if_id_en = 1'b1;
        end
      end

      ST_DRAIN: begin
        bus.o_stall  = 1'b0;
        bus.o_bubble = 1'b1;
        if (r_dcnt == '0) w_next     = ST_HALTED;
        else              w_dcnt_nxt = r_dcnt - 1'b1;
      end

      ST_HALTED: begin
        bus.o_halt = 1'b1;
      end

      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.o_state  = r_state;
  assign bus.o_cycles = r_cycles;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: each stimulus cycle pushes the expected outputs for that
// cycle; a monitor on the falling edge pops and compares.
module tb_pipeline_sequencer;
  import pipeline_pkg::*;

  localparam int NB   = 32;
  localparam int NB_S = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_s;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.NB_DATA(NB))   bus ();
  pipeline_sequencer_if #(.NB_DATA(NB_S)) sbus ();

  pipeline_sequencer #(.NB_DATA(NB), .PIPE_DRAIN(4)) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  // Narrow counter instance to exercise saturation in a few cycles.
  pipeline_sequencer #(.NB_DATA(NB_S), .PIPE_DRAIN(4)) dut_sat (
    .clk(clk), .i_rst_n(rst_s), .bus(sbus)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [5:0]    outs;   // {pc_en, if_id_en, bubble, flush, stall, halt}
    logic [NB-1:0] cyc;
  } exp_t;

  localparam logic [5:0] O_IDLE  = 6'b000010;
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_HOLD  = 6'b001000;  // hazard, halt-taken, drain
  localparam logic [5:0] O_BR    = 6'b111100;
  localparam logic [5:0] O_HALTD = 6'b000011;

  exp_t q[$];
  exp_t sq[$];
  int checks = 0;
  int failures = 0;
  int vec = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a.st   = bus.o_state;
      a.outs = {bus.o_pc_en, bus.o_if_id_en, bus.o_bubble, bus.o_flush_if_id,
                bus.o_stall, bus.o_halt};
      a.cyc  = bus.o_cycles;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL vec%0d: got st=%0d outs=%b cyc=%0d, want st=%0d outs=%b cyc=%0d",
                 vec, a.st, a.outs, a.cyc, e.st, e.outs, e.cyc);
      end
      vec++;
    end
    if (sq.size() > 0) begin
      exp_t e;
      e = sq.pop_front();
      checks++;
      if (sbus.o_state !== e.st || {{(NB-NB_S){1'b0}}, sbus.o_cycles} !== e.cyc) begin
        failures++;
        $display("FAIL sat: got st=%0d cyc=%0d, want st=%0d cyc=%0d",
                 sbus.o_state, sbus.o_cycles, e.st, e.cyc);
      end
    end
  end

  task automatic drv(input logic run, input logic step, input logic halt,
                     input logic mrd, input int ert, input int rs, input int rt,
                     input logic br);
    bus.i_run          = run;
    bus.i_step         = step;
    bus.i_halt_instr   = halt;
    bus.i_ex_memRead   = mrd;
    bus.i_ex_rt        = 5'(ert);
    bus.i_id_rs        = 5'(rs);
    bus.i_id_rt        = 5'(rt);
    bus.i_branch_taken = br;
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic cyc(input state_e st, input logic [5:0] outs, input int c);
    exp_t e;
    e.st = st; e.outs = outs; e.cyc = NB'(c);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; rst_s = 1'b0;
    idle_in();
    sbus.i_run = 1'b0; sbus.i_step = 1'b0; sbus.i_halt_instr = 1'b0;
    sbus.i_ex_memRead = 1'b0; sbus.i_ex_rt = '0; sbus.i_id_rs = '0;
    sbus.i_id_rt = '0; sbus.i_branch_taken = 1'b0;
    @(posedge clk); #1;
    cyc(ST_IDLE, O_IDLE, 0);                     // held in reset
    rst_n = 1'b1; rst_s = 1'b1; sbus.i_run = 1'b1;

    // Start and basic run
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc(ST_IDLE, O_IDLE, 0);
    idle_in();                   cyc(ST_RUN,  O_RUN,  0);
    drv(0, 1, 0, 0, 0, 0, 0, 0); cyc(ST_RUN,  O_RUN,  1);  // step ignored in RUN
    // Load-use hazards
    drv(0, 0, 0, 1, 8, 8, 0, 0); cyc(ST_RUN,  O_HOLD, 2);
    idle_in();                   cyc(ST_RUN,  O_RUN,  3);
    drv(0, 0, 0, 1, 0, 0, 0, 0); cyc(ST_RUN,  O_RUN,  4);  // r0 never hazards
    drv(0, 0, 0, 1, 5, 3, 5, 0); cyc(ST_RUN,  O_HOLD, 5);  // match on rt
    drv(0, 0, 0, 1, 8, 9, 10, 0); cyc(ST_RUN, O_RUN,  6);
    drv(0, 0, 0, 0, 8, 8, 8, 0); cyc(ST_RUN,  O_RUN,  7);  // not a load
    // Branch priority
    drv(0, 0, 0, 1, 8, 8, 0, 1); cyc(ST_RUN,  O_BR,   8);
    drv(0, 0, 1, 0, 0, 0, 0, 1); cyc(ST_RUN,  O_BR,   9);  // wrong-path halt
    // Halt behind hazard, then taken
    drv(0, 0, 1, 1, 8, 8, 0, 0); cyc(ST_RUN,  O_HOLD, 10);
    drv(0, 0, 1, 0, 0, 0, 0, 0); cyc(ST_RUN,  O_HOLD, 11);
    idle_in();
    cyc(ST_DRAIN, O_HOLD, 12);
    cyc(ST_DRAIN, O_HOLD, 13);
    cyc(ST_DRAIN, O_HOLD, 14);
    cyc(ST_DRAIN, O_HOLD, 15);
    cyc(ST_HALTED, O_HALTD, 16);
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc(ST_HALTED, O_HALTD, 16);
    drv(0, 1, 0, 0, 0, 0, 0, 0); cyc(ST_HALTED, O_HALTD, 16);
    idle_in(); rst_n = 1'b0;     cyc(ST_HALTED, O_HALTD, 16);
    rst_n = 1'b1;                cyc(ST_IDLE, O_IDLE, 0);

    // Single step
    drv(0, 1, 0, 0, 0, 0, 0, 0); cyc(ST_IDLE, O_IDLE, 0);
    idle_in();                   cyc(ST_STEP, O_RUN,  0);
    cyc(ST_IDLE, O_IDLE, 1);
    cyc(ST_IDLE, O_IDLE, 1);
    drv(1, 1, 0, 0, 0, 0, 0, 0); cyc(ST_IDLE, O_IDLE, 1);  // run wins
    idle_in();                   cyc(ST_RUN,  O_RUN,  1);
    rst_n = 1'b0;                cyc(ST_RUN,  O_RUN,  2);
    rst_n = 1'b1;

    // Halt during a step, reset on second drain cycle
    drv(0, 1, 0, 0, 0, 0, 0, 0); cyc(ST_IDLE, O_IDLE, 0);
    drv(0, 0, 1, 0, 0, 0, 0, 0); cyc(ST_STEP, O_HOLD, 0);
    idle_in();                   cyc(ST_DRAIN, O_HOLD, 1);
    rst_n = 1'b0; drv(1, 0, 0, 0, 0, 0, 0, 0); cyc(ST_DRAIN, O_HOLD, 2);
    rst_n = 1'b1; idle_in();     cyc(ST_IDLE, O_IDLE, 0);

    // Saturation of the narrow counter (it has been running many cycles)
    begin
      exp_t e;
      e.st = ST_RUN; e.outs = '0; e.cyc = NB'(7);
      sq.push_back(e);
      @(posedge clk); #1;
      sq.push_back(e);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    if (q.size() != 0 || sq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size() + sq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter: NB_DATA, 32, width of cycle counter.
REQ-002 Parameter: PIPE_DRAIN, 4, cycles needed to empty ID/EX, EX/MEM, MEM/WB after fetch stops.
REQ-003 Port: clk  in  1  single clock, rising edge.
REQ-004 Port: i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: i_run  in  1  start continuous execution.
REQ-006 Port: i_step  in  1  advance pipeline one cycle.
REQ-007 Port: i_halt_instr  in  1  HALT opcode decoded in ID.
REQ-008 Port: i_ex_memRead  in  1  instruction in EX is a load.
REQ-009 Port: i_ex_rt  in  5  load destination register in EX.
REQ-010 Port: i_id_rs, i_id_rt  in  5 each  source registers in ID.
REQ-011 Port: i_branch_taken  in  1  jump/branch resolved taken this cycle.
REQ-012 Port: o_pc_en, o_if_id_en  out  1 each  PC and IF/ID write enables.
REQ-013 Port: o_bubble  out  1  zero control signals into ID/EX.
REQ-014 Port: o_flush_if_id  out  1  replace IF/ID with NOP.
REQ-015 Port: o_stall, o_halt  out  1 each  drive execute-stage i_stall and i_halt.
REQ-016 Port: o_state  out  3  current FSM state; o_cycles  out  NB_DATA  executed cycles.

Function
REQ-017 FSM states: IDLE, RUN, STEP, DRAIN, HALTED; state registered, outputs combinational from state and current inputs (zero-latency hazard response).
REQ-018 IDLE: o_pc_en=o_if_id_en=0, o_stall=1, o_halt=0; i_run -> RUN; else i_step -> STEP; i_run has priority over simultaneous i_step.
REQ-019 STEP: behaves exactly as RUN for one cycle, then -> IDLE (or -> DRAIN if halt taken that cycle).
REQ-020 RUN/STEP default: o_pc_en=o_if_id_en=1, o_bubble=o_flush_if_id=o_stall=o_halt=0; i_step in RUN ignored.
REQ-021 Load-use hazard = i_ex_memRead & (i_ex_rt!=0) & (i_ex_rt==i_id_rs | i_ex_rt==i_id_rt); on hazard: o_pc_en=o_if_id_en=0, o_bubble=1, for exactly each cycle condition holds.
REQ-022 i_branch_taken: o_flush_if_id=1, o_bubble=1, o_pc_en=1; branch overrides simultaneous hazard and i_halt_instr (wrong-path halt discarded).
REQ-023 i_halt_instr in RUN/STEP without hazard or branch: o_pc_en=o_if_id_en=0, o_bubble=1 that cycle; next state DRAIN, drain counter loaded to PIPE_DRAIN-1.
REQ-024 i_halt_instr with hazard and no branch: hazard response only; halt recognised when hazard clears.
REQ-025 DRAIN: o_pc_en=o_if_id_en=0, o_bubble=1, o_stall=0; counter decrements each cycle; at 0 -> HALTED; total DRAIN residency PIPE_DRAIN cycles.
REQ-026 HALTED: all enables 0, o_stall=1, o_halt=1; exit only by reset; i_run/i_step ignored.
REQ-027 o_cycles increments in RUN, STEP, DRAIN; holds in IDLE, HALTED; saturates at 2^NB_DATA-1 (no wrap).

Reset
REQ-028 i_rst_n=0 at rising clk: state IDLE, drain counter 0, o_cycles 0; outputs then take IDLE values (o_pc_en=0, o_stall=1, o_halt=0, o_bubble=0, o_flush_if_id=0).
REQ-029 Reset in any state, including mid-DRAIN, wins over all other inputs in the same cycle.

Structure
REQ-030 Shared package pipeline_pkg: state encodings (IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4) and PIPE_DRAIN default.
REQ-031 One combinational sub-module hazard_detector computes load-use hazard (REQ-021); FSM, counters, output decode stay in top.

Verification
REQ-032 Reset, i_run=1 one cycle -> o_state RUN next cycle, o_pc_en=1, o_cycles=1 after one further edge.
REQ-033 RUN, i_ex_memRead=1, i_ex_rt=8, i_id_rs=8 for 1 cycle -> o_pc_en=0, o_bubble=1 that cycle only; i_ex_rt=0 same case -> no stall.
REQ-034 Same hazard plus i_branch_taken=1 -> o_flush_if_id=1, o_bubble=1, o_pc_en=1.
REQ-035 RUN, i_halt_instr=1 -> DRAIN 4 cycles, then HALTED with o_halt=1, o_cycles frozen; i_run afterwards -> no change.
REQ-036 IDLE, i_step=1 and i_run=0 -> exactly one cycle o_pc_en=1, return IDLE, o_cycles +1; i_step with i_run -> RUN.
REQ-037 Reset asserted on 2nd DRAIN cycle -> IDLE, o_cycles=0 next cycle; preset counter 32'hFFFFFFFF in RUN -> stays FFFFFFFF.
